// File: rtl/mips_bus_pkg.sv
// Shared types for the Harvard bus arbiter: FSM states, requester ids and the
// all-lanes byteenable used for reads.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

  // Wide enough for any supported data width; users slice the lanes they need.
  localparam int BYTEEN_MAX_W = 64;
  localparam logic [BYTEEN_MAX_W-1:0] BYTEEN_ALL = '1;

endpackage

// File: rtl/harvard_bus_arbiter_if.sv
// Bundle of the CPU request ports and the shared memory bus.
// master: the arbiter's view (drives completions and the memory command).
// slave:  the environment's view (CPU requesters plus the memory device).
interface harvard_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  instr_req;
  logic [ADDR_W-1:0]     instr_address;
  logic [DATA_W-1:0]     instr_readdata;
  logic                  instr_done;

  logic                  data_read;
  logic                  data_write;
  logic [ADDR_W-1:0]     data_address;
  logic [DATA_W/8-1:0]   data_byteenable;
  logic [DATA_W-1:0]     data_writedata;
  logic [DATA_W-1:0]     data_readdata;
  logic                  data_done;

  logic [ADDR_W-1:0]     mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_W/8-1:0]   mem_byteenable;
  logic [DATA_W-1:0]     mem_writedata;
  logic                  mem_waitrequest;
  logic [DATA_W-1:0]     mem_readdata;

  logic                  bus_error;

  modport master (
    input  instr_req, instr_address,
    output instr_readdata, instr_done,
    input  data_read, data_write, data_address, data_byteenable, data_writedata,
    output data_readdata, data_done,
    output mem_address, mem_read, mem_write, mem_byteenable, mem_writedata,
    input  mem_waitrequest, mem_readdata,
    output bus_error
  );

  modport slave (
    output instr_req, instr_address,
    input  instr_readdata, instr_done,
    output data_read, data_write, data_address, data_byteenable, data_writedata,
    input  data_readdata, data_done,
    input  mem_address, mem_read, mem_write, mem_byteenable, mem_writedata,
    output mem_waitrequest, mem_readdata,
    input  bus_error
  );

endinterface

// File: rtl/bus_timeout_counter.sv
// Watchdog for a stalled bus command. Down-counter loaded with LIMIT; each
// stalled cycle decrements it, reaching zero sets a sticky error flag. The
// count holds at zero and reloads on every accepted command.
module bus_timeout_counter #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic err
);

  localparam int             CNT_W    = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] remain;

  // Count down stalled cycles; flag is only cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remain <= CNT_INIT;
      err    <= 1'b0;
    end else if (clr) begin
      remain <= CNT_INIT;
    end else if (inc && (remain != '0)) begin
      remain <= remain - CNT_ONE;
      if (remain == CNT_ONE) err <= 1'b1;
    end
  end

endmodule

// File: rtl/harvard_bus_arbiter.sv
// Shares one single-port memory bus between the instruction-fetch and data
// ports of the core. Arbitration mode is selected at build time:
//   HARVARD_ARB_RR_EN defined   -> round-robin on simultaneous requests
//   HARVARD_ARB_RR_EN undefined -> fixed priority, data port wins
//
// state | meaning
// IDLE  | no command on the bus; arbitrate and latch the winner's command
// ISSUE | command held on the bus until waitrequest drops
// RESP  | read accepted; capture mem_readdata and pulse the winner's done
module harvard_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 rst_n,
  harvard_bus_arbiter_if.master bus
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        state;
  req_id_t           grant_q;
  req_id_t           winner;
  logic              any_req;
  logic              win_is_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic              tmo_inc;
  logic              tmo_clr;
`ifdef HARVARD_ARB_RR_EN
  req_id_t           last_grant;
`endif

  // Pick the requester to serve next; a simultaneous read+write is a read.
  always_comb begin
    any_req = bus.instr_req | bus.data_read | bus.data_write;
    winner  = REQ_INSTR;
`ifdef HARVARD_ARB_RR_EN
    if (bus.instr_req && (bus.data_read || bus.data_write))
      winner = (last_grant == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
    else if (bus.data_read || bus.data_write)
      winner = REQ_DATA;
`else
    if (bus.data_read || bus.data_write)
      winner = REQ_DATA;
`endif
    win_is_wr = (winner == REQ_DATA) && bus.data_write && !bus.data_read;
    sel_addr  = (winner == REQ_DATA) ? bus.data_address : bus.instr_address;
  end

  assign tmo_inc = (state == ISSUE) &&  bus.mem_waitrequest;
  assign tmo_clr = (state == ISSUE) && !bus.mem_waitrequest;

  // Arbitration FSM; every bus and completion output is a register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      grant_q            <= REQ_INSTR;
`ifdef HARVARD_ARB_RR_EN
      last_grant         <= REQ_INSTR;
`endif
      bus.mem_address    <= '0;
      bus.mem_read       <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_byteenable <= '0;
      bus.mem_writedata  <= '0;
      bus.instr_readdata <= '0;
      bus.instr_done     <= 1'b0;
      bus.data_readdata  <= '0;
      bus.data_done      <= 1'b0;
    end else begin
      bus.instr_done <= 1'b0;
      bus.data_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_q         <= winner;
`ifdef HARVARD_ARB_RR_EN
            last_grant      <= winner;
`endif
            bus.mem_address <= sel_addr;
            if (win_is_wr) begin
              bus.mem_write      <= 1'b1;
              bus.mem_byteenable <= bus.data_byteenable;
              bus.mem_writedata  <= bus.data_writedata;
            end else begin
              bus.mem_read       <= 1'b1;
              bus.mem_byteenable <= BYTEEN_ALL[BE_W-1:0];
              bus.mem_writedata  <= '0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.mem_waitrequest) begin
            bus.mem_address    <= '0;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_byteenable <= '0;
            bus.mem_writedata  <= '0;
            if (bus.mem_read) begin
              state <= RESP;
            end else begin
              // Writes only ever come from the data port.
              bus.data_done <= 1'b1;
              state         <= IDLE;
            end
          end
        end
        RESP: begin
          if (grant_q == REQ_DATA) begin
            bus.data_readdata <= bus.mem_readdata;
            bus.data_done     <= 1'b1;
          end else begin
            bus.instr_readdata <= bus.mem_readdata;
            bus.instr_done     <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  bus_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (tmo_inc),
    .clr  (tmo_clr),
    .err  (bus.bus_error)
  );

endmodule

// File: tb/tb_harvard_bus_arbiter.sv
// Bench for harvard_bus_arbiter: memory device model with configurable stall,
// scoreboard of expected completions popped on each done pulse.
module tb_harvard_bus_arbiter;
  import mips_bus_pkg::*;

  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int TIMEOUT_CYCLES = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  harvard_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc();

  harvard_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  typedef struct { bit is_data; bit is_write; logic [31:0] data; } exp_t;
  typedef struct { bit is_write; logic [31:0] addr; logic [3:0] be; } acc_t;

  exp_t        sb[$];
  acc_t        acc_log[$];
  logic [31:0] mem_img [logic [31:0]];

  int n_chk = 0;
  int n_pass = 0;
  int stall_cfg = 0;
  int stall_ct = 0;
  bit stuck = 1'b0;
  int wr_cycles = 0;
  int n_done_i = 0;
  int n_done_d = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2402_0005;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return model_word(a);
  endfunction

  // Memory device: sample the command just before each edge, respond 1 ns after.
  initial begin
    logic        cmd_pre, rd_pre, wr_pre, wreq_pre, acc, cmd_post;
    logic [31:0] addr_pre, wd_pre, w;
    logic [3:0]  be_pre;
    ifc.mem_waitrequest = 1'b0;
    ifc.mem_readdata    = '0;
    forever begin
      @(posedge clk);
      rd_pre   = ifc.mem_read;
      wr_pre   = ifc.mem_write;
      cmd_pre  = rd_pre | wr_pre;
      wreq_pre = ifc.mem_waitrequest;
      addr_pre = ifc.mem_address;
      be_pre   = ifc.mem_byteenable;
      wd_pre   = ifc.mem_writedata;
      if (wr_pre) wr_cycles++;
      if (cmd_pre && wreq_pre && stall_ct > 0) stall_ct--;
      acc = cmd_pre && !wreq_pre;
      if (acc) acc_log.push_back('{wr_pre, addr_pre, be_pre});
      if (acc && wr_pre && !rd_pre) begin
        w = mem_rd(addr_pre);
        for (int b = 0; b < 4; b++)
          if (be_pre[b]) w[8*b +: 8] = wd_pre[8*b +: 8];
        mem_img[addr_pre] = w;
      end
      #1;
      ifc.mem_readdata = (acc && rd_pre) ? mem_rd(addr_pre) : 32'hBAD0_BAD0;
      cmd_post = ifc.mem_read | ifc.mem_write;
      if (cmd_post && !cmd_pre) stall_ct = stall_cfg;
      ifc.mem_waitrequest = stuck || (cmd_post && stall_ct > 0);
    end
  end

  task automatic sb_pop_check(input bit port_is_data, input logic [31:0] rd,
                              input logic [31:0] prev_rd);
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("done_port", 32'(port_is_data), 32'(e.is_data));
      if (e.is_write) chk("wr_rdata_hold", rd, prev_rd);
      else            chk("rd_data", rd, e.data);
    end
  endtask

  // Completion monitor: pops the scoreboard on done, else readdata must hold.
  initial begin
    logic [31:0] prev_i, prev_d;
    prev_i = '0;
    prev_d = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_i = ifc.instr_readdata;
        prev_d = ifc.data_readdata;
        continue;
      end
      chk("done_overlap", 32'(ifc.instr_done & ifc.data_done), 32'd0);
      if (ifc.instr_done) begin
        n_done_i++;
        sb_pop_check(1'b0, ifc.instr_readdata, prev_i);
      end else begin
        chk("instr_rdata_hold", ifc.instr_readdata, prev_i);
      end
      if (ifc.data_done) begin
        n_done_d++;
        sb_pop_check(1'b1, ifc.data_readdata, prev_d);
      end else begin
        chk("data_rdata_hold", ifc.data_readdata, prev_d);
      end
      prev_i = ifc.instr_readdata;
      prev_d = ifc.data_readdata;
    end
  end

  task automatic wait_done(input bit is_data, output int lat);
    lat = -1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (is_data ? ifc.data_done : ifc.instr_done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic wait_sb_empty(input string tag);
    for (int c = 0; c < 200; c++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  // One requester issuing two reads back-to-back, dropping after the second.
  task automatic req_seq(input bit is_data, input logic [31:0] a0, input logic [31:0] a1);
    int lat;
    if (is_data) begin ifc.data_address = a0; ifc.data_read = 1'b1; end
    else begin ifc.instr_address = a0; ifc.instr_req = 1'b1; end
    wait_done(is_data, lat);
    chk("t3_first_done", 32'(lat > 0), 32'd1);
    if (is_data) ifc.data_address = a1;
    else         ifc.instr_address = a1;
    wait_done(is_data, lat);
    chk("t3_second_done", 32'(lat > 0), 32'd1);
    if (is_data) ifc.data_read = 1'b0;
    else         ifc.instr_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, d0, i0;
    logic [31:0] w1000, exp1000;

    rst_n               = 1'b0;
    ifc.instr_req       = 1'b0;
    ifc.instr_address   = '0;
    ifc.data_read       = 1'b0;
    ifc.data_write      = 1'b0;
    ifc.data_address    = '0;
    ifc.data_byteenable = '0;
    ifc.data_writedata  = '0;

    repeat (3) @(negedge clk);
    chk("rst_mem_read",   32'(ifc.mem_read), 32'd0);
    chk("rst_mem_write",  32'(ifc.mem_write), 32'd0);
    chk("rst_mem_addr",   ifc.mem_address, 32'd0);
    chk("rst_mem_be",     32'(ifc.mem_byteenable), 32'd0);
    chk("rst_instr_done", 32'(ifc.instr_done), 32'd0);
    chk("rst_data_done",  32'(ifc.data_done), 32'd0);
    chk("rst_bus_error",  32'(ifc.bus_error), 32'd0);
    chk("rst_instr_rd",   ifc.instr_readdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Instruction fetch, no wait states.
    acc_log.delete();
    ifc.instr_address = 32'hBFC0_0000;
    ifc.instr_req     = 1'b1;
    sb.push_back('{1'b0, 1'b0, 32'h2402_0005});
    wait_done(1'b0, lat);
    ifc.instr_req = 1'b0;
    chk("t1_latency", lat, 32'd3);
    chk("t1_rdata", ifc.instr_readdata, 32'h2402_0005);
    chk("t1_acc_count", 32'(acc_log.size()), 32'd1);
    if (acc_log.size() > 0) begin
      chk("t1_be",   32'(acc_log[0].be), 32'hF);
      chk("t1_op",   32'(acc_log[0].is_write), 32'd0);
      chk("t1_addr", acc_log[0].addr, 32'hBFC0_0000);
    end
    @(negedge clk);

    // Partial write with two wait states.
    stall_cfg = 2;
    wr_cycles = 0;
    acc_log.delete();
    d0 = n_done_d;
    w1000   = model_word(32'h1000);
    exp1000 = {w1000[31:16], 16'hBEEF};
    ifc.data_address    = 32'h1000;
    ifc.data_byteenable = 4'b0011;
    ifc.data_writedata  = 32'hDEAD_BEEF;
    ifc.data_write      = 1'b1;
    sb.push_back('{1'b1, 1'b1, 32'h0});
    wait_done(1'b1, lat);
    ifc.data_write = 1'b0;
    chk("t2_latency", lat, 32'd4);
    chk("t2_write_cycles", wr_cycles, 32'd3);
    chk("t2_acc_count", 32'(acc_log.size()), 32'd1);
    if (acc_log.size() > 0) begin
      chk("t2_be", 32'(acc_log[0].be), 32'h3);
      chk("t2_op", 32'(acc_log[0].is_write), 32'd1);
    end
    chk("t2_mem_contents", mem_rd(32'h1000), exp1000);
    repeat (4) @(negedge clk);
    chk("t2_done_pulses", n_done_d - d0, 32'd1);
    stall_cfg = 0;

    // Read and write requested together: served as a read.
    acc_log.delete();
    ifc.data_address    = 32'h1000;
    ifc.data_byteenable = 4'hC;
    ifc.data_writedata  = 32'h1234_5678;
    ifc.data_read       = 1'b1;
    ifc.data_write      = 1'b1;
    sb.push_back('{1'b1, 1'b0, exp1000});
    wait_done(1'b1, lat);
    ifc.data_read  = 1'b0;
    ifc.data_write = 1'b0;
    chk("t6_latency", lat, 32'd3);
    chk("t6_rdata", ifc.data_readdata, exp1000);
    if (acc_log.size() > 0) begin
      chk("t6_op", 32'(acc_log[0].is_write), 32'd0);
      chk("t6_be", 32'(acc_log[0].be), 32'hF);
    end
    chk("t6_mem_untouched", mem_rd(32'h1000), exp1000);
    @(negedge clk);

    // Reset while a read is stalled in ISSUE.
    stall_cfg = 3;
    ifc.instr_address = 32'hBFC0_0010;
    ifc.instr_req     = 1'b1;
    @(negedge clk);
    chk("t5_in_issue", 32'(ifc.mem_read), 32'd1);
    i0 = n_done_i;
    d0 = n_done_d;
    rst_n         = 1'b0;
    ifc.instr_req = 1'b0;
    @(negedge clk);
    chk("t5_mem_read_drop", 32'(ifc.mem_read), 32'd0);
    chk("t5_mem_write",     32'(ifc.mem_write), 32'd0);
    chk("t5_bus_error",     32'(ifc.bus_error), 32'd0);
    chk("t5_instr_rd_clr",  ifc.instr_readdata, 32'd0);
    chk("t5_data_rd_clr",   ifc.data_readdata, 32'd0);
    repeat (4) @(negedge clk);
    chk("t5_no_instr_done", 32'(ifc.instr_done), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    stall_cfg = 0;
    repeat (4) @(negedge clk);
    chk("t5_done_count", (n_done_i - i0) + (n_done_d - d0), 32'd0);

    // Simultaneous requesters, two transfers each.
`ifdef HARVARD_ARB_RR_EN
    sb.push_back('{1'b1, 1'b0, model_word(32'h2000)});
    sb.push_back('{1'b0, 1'b0, model_word(32'hBFC0_0004)});
    sb.push_back('{1'b1, 1'b0, model_word(32'h2004)});
    sb.push_back('{1'b0, 1'b0, model_word(32'hBFC0_0008)});
`else
    sb.push_back('{1'b1, 1'b0, model_word(32'h2000)});
    sb.push_back('{1'b1, 1'b0, model_word(32'h2004)});
    sb.push_back('{1'b0, 1'b0, model_word(32'hBFC0_0004)});
    sb.push_back('{1'b0, 1'b0, model_word(32'hBFC0_0008)});
`endif
    fork
      req_seq(1'b1, 32'h2000, 32'h2004);
      req_seq(1'b0, 32'hBFC0_0004, 32'hBFC0_0008);
    join
    wait_sb_empty("t3_drain");
    @(negedge clk);

    // Waitrequest stuck high past the timeout limit.
    stuck = 1'b1;
    ifc.data_address = 32'h3000;
    ifc.data_read    = 1'b1;
    sb.push_back('{1'b1, 1'b0, model_word(32'h3000)});
    repeat (TIMEOUT_CYCLES) @(negedge clk);
    chk("t4_err_before_limit", 32'(ifc.bus_error), 32'd0);
    @(negedge clk);
    chk("t4_err_at_limit", 32'(ifc.bus_error), 32'd1);
    repeat (20) @(negedge clk);
    chk("t4_err_held", 32'(ifc.bus_error), 32'd1);
    chk("t4_still_waiting", 32'(ifc.mem_read), 32'd1);
    stuck = 1'b0;
    wait_done(1'b1, lat);
    ifc.data_read = 1'b0;
    chk("t4_release_done", 32'(lat > 0), 32'd1);
    chk("t4_err_sticky", 32'(ifc.bus_error), 32'd1);
    wait_sb_empty("t4_drain");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_err_reset", 32'(ifc.bus_error), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
